// File: rtl/iobuf_bus_ctrl_pkg.sv
// Shared definitions for the pad-bus controller: state and direction
// encodings, grant indices and the counter-width helper.
package iobuf_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    DRIVE  = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_t;

  localparam int G_RD = 0;
  localparam int G_WR = 1;

  function automatic int cnt_w(input int turn, input int drv);
    int m;
    m = (turn > drv) ? turn : drv;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/iobuf_arb2.sv
// Two-requester arbiter; on contention the side not granted last wins.
module iobuf_arb2
  import iobuf_bus_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  dir_t last_grant;

  always_comb begin
    gnt = '0;
    if (en) begin
      gnt[G_WR] = req[G_WR] &
        (~req[G_RD] | (last_grant == DIR_READ));
      gnt[G_RD] = req[G_RD] &
        (~req[G_WR] | (last_grant == DIR_WRITE));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= DIR_READ;
    end else if (gnt[G_WR]) begin
      last_grant <= DIR_WRITE;
    end else if (gnt[G_RD]) begin
      last_grant <= DIR_READ;
    end
  end

endmodule

// File: rtl/iobuf_bus_ctrl.sv
// Sequences a shared tristate pad bus between a write and a read
// requester, with high-Z turnaround on every direction change.
module iobuf_bus_ctrl
  import iobuf_bus_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int DRV_CYCLES  = 1
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             WR_REQ,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             WR_ACK,
  input  logic             RD_REQ,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic [WIDTH-1:0] PAD_I,
  output logic             PAD_T,
  input  logic [WIDTH-1:0] PAD_O,
  output logic             BUSY
);

  localparam int CW = cnt_w(TURN_CYCLES, DRV_CYCLES);
  localparam bit HAS_TURN = (TURN_CYCLES > 0);
  localparam logic [CW-1:0] TURN_LD =
    CW'(HAS_TURN ? TURN_CYCLES - 1 : 0);
  localparam logic [CW-1:0] DRV_LD = CW'(DRV_CYCLES - 1);

  state_t           state, state_n;
  dir_t             dir, dir_n;
  dir_t             pend, pend_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] wdata, wdata_n;
  logic [1:0]       gnt;

  // A read's request is still high in its RD_VALID cycle; mask it
  // so the finished read is not granted a second time.
  iobuf_arb2 u_arb (
    .clk (C),
    .rst (CLR),
    .en  (state == IDLE),
    .req ({WR_REQ, RD_REQ & ~RD_VALID}),
    .gnt (gnt)
  );

  always_comb begin
    state_n = state;
    dir_n   = dir;
    pend_n  = pend;
    cnt_n   = cnt;
    wdata_n = wdata;
    case (state)
      IDLE: begin
        if (gnt[G_WR]) begin
          pend_n  = DIR_WRITE;
          wdata_n = WR_DATA;
          if (dir == DIR_READ && HAS_TURN) begin
            state_n = TURN;
            cnt_n   = TURN_LD;
          end else begin
            state_n = DRIVE;
            cnt_n   = DRV_LD;
            dir_n   = DIR_WRITE;
          end
        end else if (gnt[G_RD]) begin
          pend_n = DIR_READ;
          if (dir == DIR_WRITE && HAS_TURN) begin
            state_n = TURN;
            cnt_n   = TURN_LD;
          end else begin
            state_n = SAMPLE;
            dir_n   = DIR_READ;
          end
        end
      end
      TURN: begin
        if (cnt == '0) begin
          dir_n = pend;
          if (pend == DIR_WRITE) begin
            state_n = DRIVE;
            cnt_n   = DRV_LD;
          end else begin
            state_n = SAMPLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pad and handshake outputs are decoded from the next state so
  // they line up with the state they describe, yet stay registered.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state    <= IDLE;
      dir      <= DIR_READ;
      pend     <= DIR_READ;
      cnt      <= '0;
      wdata    <= '0;
      PAD_T    <= 1'b1;
      PAD_I    <= '0;
      WR_ACK   <= 1'b0;
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_n;
      dir      <= dir_n;
      pend     <= pend_n;
      cnt      <= cnt_n;
      wdata    <= wdata_n;
      PAD_T    <= (state_n != DRIVE);
      PAD_I    <= (state_n == DRIVE) ? wdata_n : '0;
      WR_ACK   <= (state_n == DRIVE) && (cnt_n == '0);
      RD_VALID <= (state == SAMPLE);
      BUSY     <= (state_n != IDLE);
      if (state == SAMPLE) begin
        RD_DATA <= PAD_O;
      end
    end
  end

endmodule

// File: tb/tb_iobuf_bus_ctrl.sv
// Scoreboard bench for iobuf_bus_ctrl: two instances
// (TURN=2/DRV=1 and TURN=0/DRV=3) driven by directed and random ops.
module tb_iobuf_bus_ctrl;

  typedef struct {
    int         u;
    bit         wr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       clr[2];
  logic       wr_req[2];
  logic       rd_req[2];
  logic       wr_ack[2];
  logic       rd_valid[2];
  logic       pad_t[2];
  logic       busy[2];
  logic [7:0] wr_data[2];
  logic [7:0] rd_data[2];
  logic [7:0] pad_i[2];
  logic [7:0] pad_o[2];

  iobuf_bus_ctrl #(
    .WIDTH(8), .TURN_CYCLES(2), .DRV_CYCLES(1)
  ) u0 (
    .C(clk), .CLR(clr[0]),
    .WR_REQ(wr_req[0]), .WR_DATA(wr_data[0]),
    .WR_ACK(wr_ack[0]),
    .RD_REQ(rd_req[0]), .RD_DATA(rd_data[0]),
    .RD_VALID(rd_valid[0]),
    .PAD_I(pad_i[0]), .PAD_T(pad_t[0]),
    .PAD_O(pad_o[0]), .BUSY(busy[0])
  );

  iobuf_bus_ctrl #(
    .WIDTH(8), .TURN_CYCLES(0), .DRV_CYCLES(3)
  ) u1 (
    .C(clk), .CLR(clr[1]),
    .WR_REQ(wr_req[1]), .WR_DATA(wr_data[1]),
    .WR_ACK(wr_ack[1]),
    .RD_REQ(rd_req[1]), .RD_DATA(rd_data[1]),
    .RD_VALID(rd_valid[1]),
    .PAD_I(pad_i[1]), .PAD_T(pad_t[1]),
    .PAD_O(pad_o[1]), .BUSY(busy[1])
  );

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  int   run[2];
  bit   mdir[2];
  bit   mlast[2];

  function automatic int tc(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic int dc(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic void check(input string name,
                                input logic [31:0] act,
                                input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h @cyc %0d",
               name, act, req, cyc);
    end
  endfunction

  // Model: turnaround is paid only when the bus direction flips;
  // returns the cycle of WR_ACK (write) or RD_VALID (read).
  function automatic int predict(input int u, input bit wr,
                                 input int g);
    int t;
    t = (mdir[u] != wr) ? tc(u) : 0;
    mdir[u]  = wr;
    mlast[u] = wr;
    return g + t + (wr ? dc(u) - 1 : 1);
  endfunction

  function automatic void push(input int u, input bit wr,
                               input logic [7:0] d,
                               input int c);
    exp_t e;
    e.u    = u;
    e.wr   = wr;
    e.data = d;
    e.cyc  = c;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      run[i] = pad_t[i] ? 0 : run[i] + 1;
      if (!pad_t[i]) begin
        check("drive_owner",
              32'(q.size() > 0 && q[0].wr && q[0].u == i
                  && busy[i]), 32'd1);
      end
      if (wr_ack[i] || rd_valid[i]) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done u%0d: got ack=%0b valid=%0b want none",
                   i, wr_ack[i], rd_valid[i]);
        end else begin
          e = q.pop_front();
          check("done_unit", 32'(i), 32'(e.u));
          check("done_kind", 32'(wr_ack[i]), 32'(e.wr));
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          if (e.wr) begin
            check("pad_i", 32'(pad_i[i]), 32'(e.data));
            check("drive_len", 32'(run[i]), 32'(dc(i)));
          end else begin
            check("rd_data", 32'(rd_data[i]), 32'(e.data));
          end
        end
      end
    end
  end

  task automatic wait_done(input int u, input bit wr);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wr ? wr_ack[u] : rd_valid[u]) return;
    end
    tests++;
    fails++;
    $display("FAIL timeout u%0d wr=%0b: got no done want done",
             u, wr);
  endtask

  task automatic check_reset(input int u);
    check("rst_pad_t", 32'(pad_t[u]), 32'd1);
    check("rst_pad_i", 32'(pad_i[u]), 32'd0);
    check("rst_wr_ack", 32'(wr_ack[u]), 32'd0);
    check("rst_rd_valid", 32'(rd_valid[u]), 32'd0);
    check("rst_rd_data", 32'(rd_data[u]), 32'd0);
    check("rst_busy", 32'(busy[u]), 32'd0);
  endtask

  // kind: 0 write, 1 read, 2 both requests raised together
  task automatic do_op(input int u, input int kind,
                       input logic [7:0] wd,
                       input logic [7:0] po, input int gap);
    int g;
    int d1;
    int d2;
    bit first;
    g = cyc + 1;
    wr_data[u] = wd;
    pad_o[u]   = po;
    if (kind < 2) begin
      d1 = predict(u, kind == 0, g);
      push(u, kind == 0, (kind == 0) ? wd : po, d1);
      if (kind == 0) wr_req[u] = 1'b1;
      else rd_req[u] = 1'b1;
      wait_done(u, kind == 0);
    end else begin
      first = !mlast[u];
      d1 = predict(u, first, g);
      d2 = predict(u, !first, first ? d1 + 2 : d1 + 1);
      push(u, first, first ? wd : po, d1);
      push(u, !first, first ? po : wd, d2);
      wr_req[u] = 1'b1;
      rd_req[u] = 1'b1;
      wait_done(u, first);
      if (first) wr_req[u] = 1'b0;
      else rd_req[u] = 1'b0;
      wait_done(u, !first);
    end
    wr_req[u] = 1'b0;
    rd_req[u] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic clr_mid_drive();
    bit found;
    found = 1'b0;
    wr_data[0] = 8'h5A;
    push(0, 1'b1, 8'h5A, predict(0, 1'b1, cyc + 1));
    wr_req[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (!pad_t[0]) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL clr_drive: got no drive want drive");
    end
    clr[0] = 1'b1;
    #1;
    check_reset(0);
    q.delete();
    wr_req[0] = 1'b0;
    mdir[0]   = 1'b0;
    mlast[0]  = 1'b0;
    #1;
    clr[0] = 1'b0;
    repeat (2) @(negedge clk);
    check_reset(0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      clr[i]     = 1'b1;
      wr_req[i]  = 1'b0;
      rd_req[i]  = 1'b0;
      wr_data[i] = 8'h00;
      pad_o[i]   = 8'h00;
      run[i]     = 0;
      mdir[i]    = 1'b0;
      mlast[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    clr[0] = 1'b0;
    clr[1] = 1'b0;
    @(negedge clk);
    check_reset(0);
    check_reset(1);

    do_op(0, 0, 8'hA5, 8'h00, 1);
    do_op(0, 0, 8'h11, 8'h00, 1);
    do_op(0, 0, 8'h22, 8'h00, 1);
    do_op(0, 1, 8'h00, 8'h3C, 1);
    do_op(0, 2, 8'h77, 8'hC3, 1);
    do_op(0, 2, 8'h88, 8'hD4, 1);
    do_op(0, 0, 8'h99, 8'h00, 1);
    clr_mid_drive();
    do_op(0, 0, 8'hE1, 8'h00, 1);

    do_op(1, 0, 8'hFF, 8'h00, 1);
    do_op(1, 0, 8'h0F, 8'h00, 1);
    do_op(1, 1, 8'h00, 8'h5C, 2);

    for (int n = 0; n < 40; n++) begin
      do_op(n % 2, int'($urandom_range(0, 2)),
            8'($urandom), 8'($urandom),
            1 + int'($urandom_range(0, 2)));
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
